// File: rtl/bft_stream_packetizer.sv
// bft_stream_packetizer: buffers a 32-bit kernel stream, stamps words into BFT
// packets (leaf, port, sequence) and gates emission on receiver credits.
`default_nettype none

module bft_stream_packetizer #(
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 4,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int PACKET_BITS           = 49,
  parameter int FIFO_DEPTH            = 4,
  parameter int CREDIT_INIT           = 128,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                     clk,
  input  logic                     ap_rst_n,
  input  logic [PAYLOAD_BITS-1:0]  din_user2pkt,
  input  logic                     vld_user2pkt,
  output logic                     ack_pkt2user,
  input  logic [NUM_LEAF_BITS-1:0] dest_leaf,
  input  logic [NUM_PORT_BITS-1:0] dest_port,
  input  logic                     credit_update,
  output logic [PACKET_BITS-1:0]   dout_pkt,
  output logic                     vld_pkt,
  input  logic                     rdy_pkt,
  output logic [NUM_ADDR_BITS:0]   credit_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int CRED_W = NUM_ADDR_BITS + 1;
  localparam logic [CRED_W+1:0] UPD_INC  = (CRED_W+2)'(FREESPACE_UPDATE_SIZE);
  localparam logic [CRED_W+1:0] CRED_MAX = {2'b00, {CRED_W{1'b1}}};

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_e;

  logic [PAYLOAD_BITS-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  state_e                   state_q, state_d;
  logic [PACKET_BITS-1:0]   pkt_q, pkt_d;
  logic [NUM_ADDR_BITS-1:0] seq_q, seq_d;
  logic [CRED_W-1:0]        credit_q, credit_d;
  logic [CRED_W+1:0]        credit_sum;
  logic                     push, load;

  assign ack_pkt2user = (cnt_q != CNT_W'(FIFO_DEPTH));
  assign push         = vld_user2pkt && ack_pkt2user;
  assign load         = (cnt_q != '0) && (credit_q != '0) &&
                        ((state_q == S_EMPTY) || rdy_pkt);

  assign dout_pkt     = pkt_q;
  assign vld_pkt      = (state_q == S_FULL);
  assign credit_count = credit_q;

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q;
    state_d    = state_q;
    pkt_d      = pkt_q;
    seq_d      = seq_q;
    credit_sum = {2'b00, credit_q};

    if (push) wptr_d = wptr_q + PTR_W'(1);
    if (load) rptr_d = rptr_q + PTR_W'(1);

    case ({push, load})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    case (state_q)
      S_EMPTY: begin
        if (load) state_d = S_FULL;
      end
      S_FULL: begin
        // Emptying also clears the word so bit 48 never shows without vld_pkt.
        if (!load && rdy_pkt) begin
          state_d = S_EMPTY;
          pkt_d   = '0;
        end
      end
      default: state_d = S_EMPTY;
    endcase

    if (load) begin
      pkt_d = {1'b1, dest_leaf, dest_port, seq_q, 1'b0, mem_q[rptr_q]};
      seq_d = seq_q + NUM_ADDR_BITS'(1);
    end

    // Load implies credit_q >= 1, so the widened sum never underflows.
    if (credit_update) credit_sum = credit_sum + UPD_INC;
    if (load)          credit_sum = credit_sum - (CRED_W+2)'(1);
    if (credit_sum > CRED_MAX) credit_d = '1;
    else                       credit_d = credit_sum[CRED_W-1:0];
  end

  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      state_q  <= S_EMPTY;
      pkt_q    <= '0;
      seq_q    <= '0;
      credit_q <= CRED_W'(CREDIT_INIT);
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      pkt_q    <= pkt_d;
      seq_q    <= seq_d;
      credit_q <= credit_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= din_user2pkt;
  end

endmodule

`default_nettype wire

// File: tb/tb_bft_stream_packetizer.sv
// Self-checking bench for bft_stream_packetizer against a queue-based reference model.
`default_nettype none

module tb_bft_stream_packetizer;

  logic        clk = 1'b0;
  logic        ap_rst_n;
  logic [31:0] din;
  logic        vld_in;
  logic        ack;
  logic [3:0]  leaf, port;
  logic        upd;
  logic [48:0] dout;
  logic        vld_pkt;
  logic        rdy;
  logic [7:0]  credit;

  bft_stream_packetizer dut (
    .clk          (clk),
    .ap_rst_n     (ap_rst_n),
    .din_user2pkt (din),
    .vld_user2pkt (vld_in),
    .ack_pkt2user (ack),
    .dest_leaf    (leaf),
    .dest_port    (port),
    .credit_update(upd),
    .dout_pkt     (dout),
    .vld_pkt      (vld_pkt),
    .rdy_pkt      (rdy),
    .credit_count (credit)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] mq[$];
  bit          m_vld;
  logic [48:0] m_dout;
  int          m_seq, m_credit;
  int          n_deliv, n_acc;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    m_vld = 0; m_dout = '0; m_seq = 0; m_credit = 128;
  endtask

  // One clock: drive inputs, advance the model by the spec rules, compare after the edge.
  task automatic step(input bit v, input logic [31:0] d, input bit r, input bit u, output bit acc);
    bit ld;
    vld_in = v; din = d; rdy = r; upd = u;
    @(posedge clk);
    acc = v && (mq.size() != 4);
    ld  = (mq.size() != 0) && (m_credit != 0) && (!m_vld || r);
    if (m_vld && r) n_deliv++;
    if (ld) begin
      m_dout = {1'b1, leaf, port, 7'(m_seq), 1'b0, mq.pop_front()};
      m_seq  = (m_seq + 1) % 128;
      m_vld  = 1;
    end else if (m_vld && r) begin
      m_vld  = 0;
      m_dout = '0;
    end
    m_credit = m_credit + (u ? 64 : 0) - (ld ? 1 : 0);
    if (m_credit > 255) m_credit = 255;
    if (acc) begin
      mq.push_back(d);
      n_acc++;
    end
    #1;
    check_eq("ack", ack, (mq.size() != 4));
    check_eq("vld", vld_pkt, m_vld);
    check_eq("dout", dout, m_dout);
    check_eq("credit", credit, m_credit);
  endtask

  task automatic do_reset();
    #2 ap_rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst_ack", ack, 1);
    check_eq("rst_vld", vld_pkt, 0);
    check_eq("rst_dout", dout, 0);
    check_eq("rst_credit", credit, 128);
    @(posedge clk);
    #1 ap_rst_n = 1'b1;
    n_deliv = 0; n_acc = 0;
  endtask

  task automatic idle(input int n, input bit r);
    bit a;
    for (int i = 0; i < n; i++) step(0, 32'h0, r, 0, a);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit          a;
    int          idx, snap;
    logic [48:0] held;

    ap_rst_n = 1'b1; din = '0; vld_in = 0; rdy = 0; upd = 0; leaf = 4'h3; port = 4'h2;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Single word, fixed expectation.
    step(1, 32'hDEADBEEF, 1, 0, a);
    step(0, 32'h0, 1, 0, a);
    check_eq("single_pkt", dout, {1'b1, 4'h3, 4'h2, 7'd0, 1'b0, 32'hDEADBEEF});
    check_eq("single_credit", credit, 127);
    step(0, 32'h0, 1, 0, a);
    check_eq("single_one_cycle", vld_pkt, 0);

    // 200-word stream with no updates: credit exhaustion, FIFO fills, then one update.
    do_reset();
    idx = 0;
    for (int c = 0; c < 200; c++) begin
      step(idx < 200, 32'h1000_0000 + idx, 1, 0, a);
      if (a) idx++;
    end
    check_eq("stream_sent", n_deliv, 128);
    check_eq("stream_accepted", n_acc, 132);
    check_eq("stream_ack_low", ack, 0);
    snap = n_deliv;
    step(idx < 200, 32'h1000_0000 + idx, 1, 1, a);
    if (a) idx++;
    for (int c = 0; c < 100; c++) begin
      step(idx < 200, 32'h1000_0000 + idx, 1, 0, a);
      if (a) idx++;
    end
    check_eq("update_sent", n_deliv - snap, 64);
    check_eq("update_credit", credit, 0);

    // Backpressure mid-stream.
    do_reset();
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      step(1, $urandom, 1, 0, a);
    end
    held = dout;
    for (int c = 0; c < 10; c++) begin
      step(1, $urandom, 0, 0, a);
      check_eq("bp_hold_dout", dout, held);
      check_eq("bp_hold_vld", vld_pkt, 1);
    end
    idle(20, 1);
    check_eq("bp_no_loss", n_deliv, n_acc);

    // Load and update together at credit 1, then saturation.
    do_reset();
    idx = 0;
    while (idx < 127) begin
      step(1, 32'hC000_0000 + idx, 1, 0, a);
      if (a) idx++;
    end
    idle(8, 1);
    check_eq("cred_one", credit, 1);
    step(1, 32'hCAFE_0001, 1, 0, a);
    step(0, 32'h0, 1, 1, a);
    check_eq("cred_sim", credit, 64);
    for (int i = 0; i < 3; i++) step(0, 32'h0, 1, 1, a);
    check_eq("cred_sat", credit, 255);
    for (int i = 0; i < 5; i++) step(1, $urandom, 1, 0, a);
    idle(4, 1);
    check_eq("cred_250", credit, 250);
    step(0, 32'h0, 1, 1, a);
    check_eq("cred_sat250", credit, 255);

    // Random traffic.
    do_reset();
    idx = 0;
    for (int c = 0; c < 20000 && idx < 1000; c++) begin
      if ($urandom_range(0, 63) == 0) begin
        leaf = 4'($urandom);
        port = 4'($urandom);
      end
      step($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1,
           $urandom_range(0, 31) == 0, a);
      if (a) idx++;
    end
    for (int c = 0; c < 400 && (mq.size() != 0 || m_vld); c++)
      step(0, 32'h0, 1, m_credit == 0, a);
    check_eq("rand_accepted", n_acc, 1000);
    check_eq("rand_delivered", n_deliv, 1000);

    // Asynchronous reset with 3 words queued and a packet on the output.
    do_reset();
    leaf = 4'h5; port = 4'h9;
    for (int i = 0; i < 4; i++) step(1, 32'hA000_0000 + i, 0, 0, a);
    check_eq("pre_rst_vld", vld_pkt, 1);
    check_eq("pre_rst_fifo", mq.size(), 3);
    do_reset();
    step(1, 32'h0BAD_F00D, 1, 0, a);
    step(0, 32'h0, 1, 0, a);
    check_eq("post_rst_seq", dout[39:33], 0);
    check_eq("post_rst_pkt", dout, {1'b1, 4'h5, 4'h9, 7'd0, 1'b0, 32'h0BAD_F00D});
    check_eq("post_rst_credit", credit, 127);
    idle(2, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
